ks_excitation: RTL

Pluck excitation generator for the Karplus-Strong voice. On a pluck trigger it emits a burst of `period` pseudo-random noise samples, one per `lrck` edge, scaled by `velocity`, then returns to silence. Its `out` feeds the string loop, which is the sample stream consumed by the dynamics lowpass. It shares that filter's sample clock, reset, 24-bit signed format and 10-bit fractional scaling rule.

---
 rtl/ks_excitation.sv | 96 +++++++++
 1 files changed

// File: rtl/ks_excitation.sv
// Karplus-Strong pluck excitation: velocity-scaled LFSR noise burst per trigger.
// Optional KS_EXCITE_TAPER_EN adds a linear fade over the last 16 burst samples.
module ks_excitation #(
    parameter logic [23:0] SEED = 24'h5A5A5A
) (
    input  logic               lrck,
    input  logic               rst_n,
    input  logic               pluck,
    input  logic [11:0]        period,
    input  logic [9:0]         velocity,
    output logic               busy,
    output logic signed [23:0] out
);

    localparam int unsigned LFSR_W = 24;
    localparam int unsigned CNT_W  = 12;
    localparam int unsigned VEL_W  = 10;
    localparam int unsigned PROD_W = LFSR_W + VEL_W;
    localparam int unsigned FRAC_W = 10;

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t                   state_q;
    logic                     pluck_q;
    logic [CNT_W-1:0]         remaining_q;
    logic [VEL_W-1:0]         vel_q;
    logic [LFSR_W-1:0]        lfsr_q;

    logic                     trig;
    logic                     trig_ok;
    logic [LFSR_W-1:0]        lfsr_d;
    logic [VEL_W-1:0]         eff_vel;
    logic signed [PROD_W-1:0] prod;
    logic signed [LFSR_W-1:0] scaled;

    assign trig    = pluck & ~pluck_q;
    assign trig_ok = trig && (period != '0);
    assign lfsr_d  = {lfsr_q[LFSR_W-2:0], lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16]};

`ifdef KS_EXCITE_TAPER_EN
    // Fade amplitude linearly once 16 or fewer samples remain.
    logic [14:0] taper_prod;
    assign taper_prod = 15'(vel_q) * 15'(remaining_q[4:0]);
    assign eff_vel    = (remaining_q <= CNT_W'(16)) ? VEL_W'(taper_prod >> 4) : vel_q;
`else
    assign eff_vel = vel_q;
`endif

    assign prod   = $signed({{VEL_W{lfsr_q[LFSR_W-1]}}, lfsr_q}) * $signed({{LFSR_W{1'b0}}, eff_vel});
    assign scaled = LFSR_W'(prod >>> FRAC_W);

    always_ff @(posedge lrck) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pluck_q     <= 1'b0;
            remaining_q <= '0;
            vel_q       <= '0;
            lfsr_q      <= SEED;
            busy        <= 1'b0;
            out         <= '0;
        end else begin
            pluck_q <= pluck;
            case (state_q)
                ST_IDLE: begin
                    out <= '0;
                    if (trig_ok) begin
                        remaining_q <= period;
                        vel_q       <= velocity;
                        busy        <= 1'b1;
                        state_q     <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    out    <= scaled;
                    lfsr_q <= lfsr_d;
                    // A retrigger reloads the burst and wins over the final-sample exit.
                    if (trig_ok) begin
                        remaining_q <= period;
                        vel_q       <= velocity;
                    end else begin
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            busy    <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
